// File: rtl/mole_game_pkg.sv
// Shared types and constants for the mole game control slice.
package mole_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned NUM_MOLES     = 3;
  localparam logic [7:0]  SCORE_MAX_BCD = 8'h99;

endpackage

// File: rtl/mole_hit_scorer_if.sv
// Player/display-facing signal bundle of the hit scorer.
interface mole_hit_scorer_if;

  logic                                 start;
  logic [mole_game_pkg::NUM_MOLES-1:0]  keys;
  logic [mole_game_pkg::NUM_MOLES-1:0]  mole;
  logic                                 game;
  logic                                 turnoff;
  logic [7:0]                           score_bcd;
  logic [1:0]                           misses;
  logic [5:0]                           time_left;
  logic                                 game_over;

  modport slave (
    input  start, keys, mole,
    output game, turnoff, score_bcd, misses, time_left, game_over
  );

  modport master (
    output start, keys, mole,
    input  game, turnoff, score_bcd, misses, time_left, game_over
  );

endinterface

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score, +1 or +2 per step, saturating at 99.
module score_bcd_counter
  import mole_game_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic       inc2,
  output logic [7:0] score
);

  logic [4:0] ones_sum;
  logic       carry;
  logic [3:0] ones_nxt;
  logic [3:0] tens_nxt;
  logic [7:0] score_nxt;

  always_comb begin
    ones_sum  = {1'b0, score[3:0]} + (inc2 ? 5'd2 : 5'd1);
    carry     = (ones_sum >= 5'd10);
    ones_nxt  = carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    tens_nxt  = score[7:4] + {3'b000, carry};
    score_nxt = {tens_nxt, ones_nxt};
    if (score[7:4] == 4'd9 && carry) begin
      score_nxt = SCORE_MAX_BCD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      score <= '0;
    end else if (inc || inc2) begin
      score <= score_nxt;
    end
  end

endmodule

// File: rtl/mole_hit_scorer.sv
// Game FSM, key conditioning, hit/miss scoring and round timer.
// Optional: STREAK_BONUS_EN (5th consecutive hit scores 2).
module mole_hit_scorer
  import mole_game_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned GAME_SECONDS  = 30,
  parameter int unsigned MAX_MISSES    = 3
) (
  input  logic               clock,
  input  logic               reset,
  mole_hit_scorer_if.slave   bus
);

  localparam logic [27:0] SEC_LAST   = 28'(TICKS_PER_SEC - 1);
  localparam logic [5:0]  ROUND_SECS = 6'(GAME_SECONDS);
  localparam logic [1:0]  MISS_LAST  = 2'(MAX_MISSES - 1);

  game_state_t state, state_nxt;

  logic                 start_s1, start_s2, start_d, start_p;
  logic [NUM_MOLES-1:0] keys_s1, keys_s2, keys_d, key_p;

  logic [27:0] sec_cnt;
  logic [5:0]  time_left_q;
  logic [1:0]  misses_q;
  logic        game_q;
  logic        turnoff_q;
  logic [7:0]  score;

  logic in_play, hit, miss, tick, time_up, miss_out, round_start;
  logic score_inc, score_inc2;

  // synchronise raw keys, then register a one-cycle rising-edge pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      start_p  <= 1'b0;
      keys_s1  <= '0;
      keys_s2  <= '0;
      keys_d   <= '0;
      key_p    <= '0;
    end else begin
      start_s1 <= bus.start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      start_p  <= start_s2 & ~start_d;
      keys_s1  <= bus.keys;
      keys_s2  <= keys_s1;
      keys_d   <= keys_s2;
      key_p    <= keys_s2 & ~keys_d;
    end
  end

  always_comb begin
    in_play     = (state == PLAY);
    hit         = in_play && |(key_p & bus.mole);
    miss        = in_play && |(key_p & ~bus.mole);
    tick        = in_play && (sec_cnt == SEC_LAST);
    time_up     = tick && (time_left_q == 6'd1);
    miss_out    = miss && (misses_q == MISS_LAST);
    round_start = start_p && (state != PLAY);
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, OVER: if (start_p) state_nxt = PLAY;
      PLAY:       if (time_up || miss_out) state_nxt = OVER;
      default:    state_nxt = IDLE;
    endcase
  end

  // round datapath: timer, misses, registered game/turnoff
  always_ff @(posedge clock) begin
    if (reset) begin
      sec_cnt     <= '0;
      time_left_q <= '0;
      misses_q    <= '0;
      game_q      <= 1'b0;
      turnoff_q   <= 1'b0;
    end else begin
      game_q    <= in_play;
      turnoff_q <= hit && (state_nxt == PLAY);
      if (round_start) begin
        sec_cnt     <= '0;
        time_left_q <= ROUND_SECS;
        misses_q    <= '0;
      end else if (in_play) begin
        if (miss) begin
          misses_q <= misses_q + 2'd1;
        end
        if (tick) begin
          sec_cnt <= '0;
          if (time_left_q != '0) begin
            time_left_q <= time_left_q - 6'd1;
          end
        end else begin
          sec_cnt <= sec_cnt + 28'd1;
        end
      end
    end
  end

`ifdef STREAK_BONUS_EN
  logic [2:0] streak_q;
  logic       bonus;

  assign bonus      = hit && !miss && (streak_q == 3'd4);
  assign score_inc  = hit && !bonus;
  assign score_inc2 = bonus;

  // consecutive-hit streak; any miss breaks it
  always_ff @(posedge clock) begin
    if (reset || round_start) begin
      streak_q <= '0;
    end else if (in_play) begin
      if (miss || bonus) begin
        streak_q <= '0;
      end else if (hit) begin
        streak_q <= streak_q + 3'd1;
      end
    end
  end
`else
  assign score_inc  = hit;
  assign score_inc2 = 1'b0;
`endif

  score_bcd_counter u_score (
    .clock (clock),
    .reset (reset),
    .clear (round_start),
    .inc   (score_inc),
    .inc2  (score_inc2),
    .score (score)
  );

  assign bus.game      = game_q;
  assign bus.turnoff   = turnoff_q;
  assign bus.score_bcd = score;
  assign bus.misses    = misses_q;
  assign bus.time_left = time_left_q;
  assign bus.game_over = (state == OVER);

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Scoreboard bench: two scorer instances (short and long rounds) share stimulus.
module tb_mole_hit_scorer;

  typedef struct {
    logic       game;
    logic       turnoff;
    logic [7:0] score_bcd;
    logic [1:0] misses;
    logic [5:0] time_left;
    logic       game_over;
  } exp_t;

  localparam int MAXM = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mole_hit_scorer_if bus0();
  mole_hit_scorer_if bus1();

  mole_hit_scorer #(.TICKS_PER_SEC(10), .GAME_SECONDS(3), .MAX_MISSES(3)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  mole_hit_scorer #(.TICKS_PER_SEC(64), .GAME_SECONDS(40), .MAX_MISSES(3)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // reference model state (per instance)
  int   ticks[2] = '{10, 64};
  int   secs[2]  = '{3, 40};
  int   m_st[2];      // 0 idle, 1 play, 2 over
  int   m_score[2];   // decimal score
  int   m_mis[2];
  int   m_tl[2];
  int   m_sc[2];
  int   m_stk[2];
  bit   m_to[2];
  bit   m_gm[2];
  logic       hs[5];
  logic [2:0] hk[5];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic void model_inst(input int i, input logic sp, input logic [2:0] kp,
                                     input logic [2:0] m);
    int ns;
    int add;
    bit play, hit, miss;
    play = (m_st[i] == 1);
    hit  = play && ((kp & m) != 3'b000);
    miss = play && ((kp & ~m) != 3'b000);
    ns   = m_st[i];
    if (!play && sp) begin
      ns = 1; m_score[i] = 0; m_mis[i] = 0; m_tl[i] = secs[i]; m_sc[i] = 0; m_stk[i] = 0;
    end
    if (play) begin
      add = 1;
`ifdef STREAK_BONUS_EN
      if (hit && !miss) begin
        if (m_stk[i] == 4) begin add = 2; m_stk[i] = 0; end
        else m_stk[i] = m_stk[i] + 1;
      end else if (miss) begin
        m_stk[i] = 0;
      end
`endif
      if (hit) m_score[i] = (m_score[i] + add > 99) ? 99 : m_score[i] + add;
      if (miss) begin
        m_mis[i] = m_mis[i] + 1;
        if (m_mis[i] == MAXM) ns = 2;
      end
      if (m_sc[i] == ticks[i] - 1) begin
        m_sc[i] = 0;
        if (m_tl[i] == 1) ns = 2;
        if (m_tl[i] > 0) m_tl[i] = m_tl[i] - 1;
      end else begin
        m_sc[i] = m_sc[i] + 1;
      end
    end
    m_gm[i] = play;
    m_to[i] = hit && (ns == 1);
    m_st[i] = ns;
  endfunction

  function automatic exp_t snap(input int i);
    exp_t e;
    e.game      = m_gm[i];
    e.turnoff   = m_to[i];
    e.score_bcd = to_bcd(m_score[i]);
    e.misses    = 2'(m_mis[i]);
    e.time_left = 6'(m_tl[i]);
    e.game_over = (m_st[i] == 2);
    return e;
  endfunction

  task automatic model_edge(input logic s, input logic [2:0] k, input logic [2:0] m,
                            input logic r);
    logic       sp;
    logic [2:0] kp;
    if (r) begin
      for (int j = 0; j < 5; j++) begin hs[j] = 1'b0; hk[j] = 3'b000; end
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_score[i] = 0; m_mis[i] = 0; m_tl[i] = 0; m_sc[i] = 0;
        m_stk[i] = 0; m_to[i] = 1'b0; m_gm[i] = 1'b0;
      end
    end else begin
      for (int j = 4; j > 0; j--) begin hs[j] = hs[j-1]; hk[j] = hk[j-1]; end
      hs[0] = s;
      hk[0] = k;
      // key press seen by the scorer: raw edge three samples back
      sp = hs[3] & ~hs[4];
      kp = hk[3] & ~hk[4];
      for (int i = 0; i < 2; i++) model_inst(i, sp, kp, m);
    end
    q0.push_back(snap(0));
    q1.push_back(snap(1));
  endtask

  task automatic step(input logic s, input logic [2:0] k, input logic [2:0] m, input logic r);
    reset      = r;
    bus0.start = s; bus1.start = s;
    bus0.keys  = k; bus1.keys  = k;
    bus0.mole  = m; bus1.mole  = m;
    @(posedge clock);
    model_edge(s, k, m, r);
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] m);
    repeat (n) step(1'b0, 3'b000, m, 1'b0);
  endtask

  task automatic press(input logic [2:0] k, input logic [2:0] m);
    step(1'b0, k, m, 1'b0);
    step(1'b0, 3'b000, m, 1'b0);
  endtask

  task automatic start_round();
    step(1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b0, 3'b000, 3'b000, 1'b0);
    idle(3, 3'b000);
  endtask

  task automatic chk(input string name, input int inst, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s[dut%0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, expv);
    end
  endtask

  // monitor: compare DUT outputs against queued expectations each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("game",      0, int'(bus0.game),      int'(e.game));
        chk("turnoff",   0, int'(bus0.turnoff),   int'(e.turnoff));
        chk("score_bcd", 0, int'(bus0.score_bcd), int'(e.score_bcd));
        chk("misses",    0, int'(bus0.misses),    int'(e.misses));
        chk("time_left", 0, int'(bus0.time_left), int'(e.time_left));
        chk("game_over", 0, int'(bus0.game_over), int'(e.game_over));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("game",      1, int'(bus1.game),      int'(e.game));
        chk("turnoff",   1, int'(bus1.turnoff),   int'(e.turnoff));
        chk("score_bcd", 1, int'(bus1.score_bcd), int'(e.score_bcd));
        chk("misses",    1, int'(bus1.misses),    int'(e.misses));
        chk("time_left", 1, int'(bus1.time_left), int'(e.time_left));
        chk("game_over", 1, int'(bus1.game_over), int'(e.game_over));
      end
    end
  end

  initial begin
    logic [2:0] mole_r;
    logic [2:0] keys_r;
    logic       rst_r, start_r;

    // reset, then a round start
    repeat (3) step(1'b0, 3'b000, 3'b000, 1'b1);
    idle(2, 3'b000);
    start_round();
    idle(2, 3'b000);

    // correct hit, then hold the key
    press(3'b010, 3'b010);
    idle(3, 3'b010);
    repeat (20) step(1'b0, 3'b010, 3'b010, 1'b0);
    idle(3, 3'b010);

    // two wrong keys at once count as one miss
    press(3'b110, 3'b001);
    idle(4, 3'b001);

    // let the clock run out, then restart
    idle(40, 3'b000);
    start_round();

    // three wrong presses end the round
    repeat (3) begin press(3'b010, 3'b001); idle(2, 3'b001); end
    idle(4, 3'b001);

    // 9 -> 10 carry
    start_round();
    repeat (10) press(3'b100, 3'b100);
    idle(4, 3'b100);

    // presses while display is blank are misses
    start_round();
    press(3'b001, 3'b000);
    idle(4, 3'b000);

    // saturation at 99 on the long-round instance
    step(1'b0, 3'b000, 3'b000, 1'b1);
    start_round();
    repeat (110) press(3'b001, 3'b001);
    idle(4, 3'b001);

    // reset in the middle of play
    step(1'b0, 3'b000, 3'b000, 1'b1);
    start_round();
    repeat (5) press(3'b010, 3'b010);
    idle(3, 3'b010);
    step(1'b0, 3'b000, 3'b010, 1'b1);
    idle(3, 3'b000);

    // five straight hits from zero
    start_round();
    repeat (5) press(3'b100, 3'b100);
    idle(4, 3'b100);

    // randomized play
    mole_r = 3'b001;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0)
        mole_r = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'(1 << $urandom_range(0, 2));
      keys_r  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      start_r = ($urandom_range(0, 29) == 0);
      rst_r   = ($urandom_range(0, 499) == 0);
      step(start_r, keys_r, mole_r, rst_r);
    end

    idle(2, 3'b000);
    @(negedge clock);
    #1;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
